// File: rtl/sirv_gnrl_apb2icb_if.sv
`default_nettype none
// ============================================================================
// Module      : sirv_gnrl_apb2icb_if
// Description : APB responder and ICB initiator signal bundle for the
//               APB-to-ICB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface sirv_gnrl_apb2icb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            apb_pselx;
   logic            apb_penable;
   logic            apb_pwrite;
   logic [AW-1:0]   apb_paddr;
   logic [DW-1:0]   apb_pwdata;
   logic [DW-1:0]   apb_prdata;
   logic            apb_pready;
   logic            apb_pslverr;

   logic            o_icb_cmd_valid;
   logic            o_icb_cmd_ready;
   logic [AW-1:0]   o_icb_cmd_addr;
   logic            o_icb_cmd_read;
   logic [DW-1:0]   o_icb_cmd_wdata;
   logic [DW/8-1:0] o_icb_cmd_wmask;
   logic [1:0]      o_icb_cmd_size;
   logic            o_icb_rsp_valid;
   logic            o_icb_rsp_ready;
   logic [DW-1:0]   o_icb_rsp_rdata;
   logic            o_icb_rsp_err;

   // Bridge view: APB responder on one side, ICB initiator on the other
   modport slave (
      input  apb_pselx, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
      output apb_prdata, apb_pready, apb_pslverr,
      output o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
      output o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_size,
      input  o_icb_cmd_ready,
      input  o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
      output o_icb_rsp_ready
   );

   // Environment view: APB master plus ICB responder
   modport master (
      output apb_pselx, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
      input  apb_prdata, apb_pready, apb_pslverr,
      input  o_icb_cmd_valid, o_icb_cmd_addr, o_icb_cmd_read,
      input  o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_size,
      output o_icb_cmd_ready,
      output o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err,
      input  o_icb_rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/sirv_gnrl_apb2icb.sv
`default_nettype none
// ============================================================================
// Module      : sirv_gnrl_apb2icb
// Description : Replays each single APB transfer as one ICB command/response
//               pair, stretching the APB access phase until the response.
// Revision    : 1.0 - initial release
// ============================================================================
module sirv_gnrl_apb2icb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sirv_gnrl_apb2icb_if.slave   bus
);

   localparam logic [1:0] c_size_word = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RSP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [AW-1:0]     r_addr;
   logic              r_read;
   logic [DW-1:0]     r_wdata;
   logic [DW/8-1:0]   r_wmask;
   logic [DW-1:0]     r_prdata;
   logic              r_err;

   logic              w_capture;
   logic              w_rsp_hs;
   logic              w_cmd_valid;
   logic              w_rsp_ready;
   logic              w_pready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs decode from the state register only; handshake inputs never
   // reach an output combinationally.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_rsp_hs    = 1'b0;
      w_cmd_valid = 1'b0;
      w_rsp_ready = 1'b0;
      w_pready    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.apb_pselx && !bus.apb_penable) begin
               w_capture   = 1'b1;
               w_state_nxt = CMD;
            end
         end
         CMD: begin
            w_cmd_valid = 1'b1;
            if (bus.o_icb_cmd_ready) begin
               w_state_nxt = RSP;
            end
         end
         RSP: begin
            w_rsp_ready = 1'b1;
            if (bus.o_icb_rsp_valid) begin
               w_rsp_hs    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_pready    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_read   <= 1'b0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_prdata <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_capture) begin
            r_addr  <= bus.apb_paddr;
            r_read  <= ~bus.apb_pwrite;
            r_wdata <= bus.apb_pwdata;
            r_wmask <= {(DW/8){bus.apb_pwrite}};
         end
         if (w_rsp_hs) begin
            r_err <= bus.o_icb_rsp_err;
            // Read data is kept across writes so the APB side sees the last read
            if (r_read) begin
               r_prdata <= bus.o_icb_rsp_rdata;
            end
         end
      end
   end

   assign bus.o_icb_cmd_valid = w_cmd_valid;
   assign bus.o_icb_cmd_addr  = r_addr;
   assign bus.o_icb_cmd_read  = r_read;
   assign bus.o_icb_cmd_wdata = r_wdata;
   assign bus.o_icb_cmd_wmask = r_wmask;
   assign bus.o_icb_cmd_size  = c_size_word;
   assign bus.o_icb_rsp_ready = w_rsp_ready;

   assign bus.apb_prdata      = r_prdata;
   assign bus.apb_pready      = w_pready;
   assign bus.apb_pslverr     = w_pready & r_err;

endmodule
`default_nettype wire

// File: tb/tb_sirv_gnrl_apb2icb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sirv_gnrl_apb2icb
// Description : Directed self-checking bench for the APB-to-ICB bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sirv_gnrl_apb2icb;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   sirv_gnrl_apb2icb_if #(.AW(32), .DW(32)) bus ();

   sirv_gnrl_apb2icb #(.AW(32), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One APB transfer with an ICB responder that holds cmd_ready low for cw
   // cycles and delays rsp_valid by rw cycles; pready is due in access cycle ec.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int cw, input int rw,
                       input logic [31:0] rsp_data, input bit rsp_err,
                       input int ec, input logic [31:0] exp_prdata, input bit exp_err);
      @(negedge clk);
      check("idle_cmd_valid", {31'd0, bus.o_icb_cmd_valid}, 32'd0);
      check("idle_pready",    {31'd0, bus.apb_pready},      32'd0);
      bus.apb_pselx   = 1'b1;
      bus.apb_penable = 1'b0;
      bus.apb_pwrite  = wr;
      bus.apb_paddr   = addr;
      bus.apb_pwdata  = wdata;
      @(posedge clk);
      #1;
      bus.apb_penable = 1'b1;
      for (int n = 1; n <= ec; n++) begin
         bus.o_icb_cmd_ready = (n == cw + 1);
         bus.o_icb_rsp_valid = (n == cw + 2 + rw);
         bus.o_icb_rsp_rdata = (n == cw + 2 + rw) ? rsp_data : 32'h5555_AAAA;
         bus.o_icb_rsp_err   = (n == cw + 2 + rw) ? rsp_err : 1'b0;
         @(negedge clk);
         check("pready",    {31'd0, bus.apb_pready},      {31'd0, n == ec});
         check("cmd_valid", {31'd0, bus.o_icb_cmd_valid}, {31'd0, n <= cw + 1});
         check("rsp_ready", {31'd0, bus.o_icb_rsp_ready},
               {31'd0, (n >= cw + 2) && (n <= cw + 2 + rw)});
         if (n <= cw + 1) begin
            check("cmd_addr",  bus.o_icb_cmd_addr, addr);
            check("cmd_read",  {31'd0, bus.o_icb_cmd_read}, {31'd0, ~wr});
            check("cmd_wmask", {28'd0, bus.o_icb_cmd_wmask}, wr ? 32'hF : 32'h0);
            check("cmd_size",  {30'd0, bus.o_icb_cmd_size}, 32'h2);
            if (wr) check("cmd_wdata", bus.o_icb_cmd_wdata, wdata);
         end
         if (n == ec) begin
            check("prdata",  bus.apb_prdata, exp_prdata);
            check("pslverr", {31'd0, bus.apb_pslverr}, {31'd0, exp_err});
         end
         @(posedge clk);
         #1;
      end
      bus.apb_pselx       = 1'b0;
      bus.apb_penable     = 1'b0;
      bus.o_icb_cmd_ready = 1'b0;
      bus.o_icb_rsp_valid = 1'b0;
      bus.o_icb_rsp_err   = 1'b0;
   endtask

   initial begin
      tests_run           = 0;
      tests_failed        = 0;
      rst_n               = 1'b0;
      bus.apb_pselx       = 1'b0;
      bus.apb_penable     = 1'b0;
      bus.apb_pwrite      = 1'b0;
      bus.apb_paddr       = '0;
      bus.apb_pwdata      = '0;
      bus.o_icb_cmd_ready = 1'b0;
      bus.o_icb_rsp_valid = 1'b0;
      bus.o_icb_rsp_rdata = '0;
      bus.o_icb_rsp_err   = 1'b0;

      // Reset values
      #12;
      check("rst_cmd_valid", {31'd0, bus.o_icb_cmd_valid}, 32'd0);
      check("rst_rsp_ready", {31'd0, bus.o_icb_rsp_ready}, 32'd0);
      check("rst_pready",    {31'd0, bus.apb_pready},      32'd0);
      check("rst_pslverr",   {31'd0, bus.apb_pslverr},     32'd0);
      check("rst_prdata",    bus.apb_prdata,               32'd0);
      check("rst_cmd_read",  {31'd0, bus.o_icb_cmd_read},  32'd0);
      check("rst_cmd_size",  {30'd0, bus.o_icb_cmd_size},  32'h2);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait read, then write keeps prdata
      xfer(1'b0, 32'h1001_3005, 32'h0, 0, 0, 32'h0000_00C1, 1'b0, 3, 32'h0000_00C1, 1'b0);
      xfer(1'b1, 32'h1001_3000, 32'hA5A5_0F0F, 0, 0, 32'h1234_5678, 1'b0, 3, 32'h0000_00C1, 1'b0);

      // Back-pressure: 3 cmd stalls + 2 rsp stalls -> pready in cycle 8
      xfer(1'b1, 32'h1001_3010, 32'h0BAD_F00D, 3, 2, 32'h8765_4321, 1'b0, 8, 32'h0000_00C1, 1'b0);
      xfer(1'b0, 32'h1001_3008, 32'h0, 3, 2, 32'h1122_3344, 1'b0, 8, 32'h1122_3344, 1'b0);

      // Error response, then a clean one
      xfer(1'b0, 32'h1001_3020, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b1, 3, 32'hDEAD_BEEF, 1'b1);
      xfer(1'b0, 32'h1001_3024, 32'h0, 0, 1, 32'h0000_0007, 1'b0, 4, 32'h0000_0007, 1'b0);
      xfer(1'b1, 32'h1001_3028, 32'h0000_0001, 0, 0, 32'hFFFF_FFFF, 1'b1, 3, 32'h0000_0007, 1'b1);

      // Back-to-back read then write
      xfer(1'b0, 32'h1001_3005, 32'h0, 0, 0, 32'h0000_00C2, 1'b0, 3, 32'h0000_00C2, 1'b0);
      xfer(1'b1, 32'h1001_3004, 32'h0000_0099, 0, 0, 32'h0000_0000, 1'b0, 3, 32'h0000_00C2, 1'b0);

      // Reset while waiting for the response
      @(negedge clk);
      bus.apb_pselx   = 1'b1;
      bus.apb_penable = 1'b0;
      bus.apb_pwrite  = 1'b0;
      bus.apb_paddr   = 32'h1001_3040;
      @(posedge clk);
      #1;
      bus.apb_penable     = 1'b1;
      bus.o_icb_cmd_ready = 1'b1;
      @(negedge clk);
      check("pre_rst_cmd_valid", {31'd0, bus.o_icb_cmd_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus.o_icb_cmd_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_rsp_ready", {31'd0, bus.o_icb_rsp_ready}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_ready", {31'd0, bus.o_icb_rsp_ready}, 32'd0);
      check("mid_rst_cmd_valid", {31'd0, bus.o_icb_cmd_valid}, 32'd0);
      check("mid_rst_pready",    {31'd0, bus.apb_pready},      32'd0);
      check("mid_rst_prdata",    bus.apb_prdata,               32'd0);
      check("mid_rst_cmd_addr",  bus.o_icb_cmd_addr,           32'd0);
      bus.apb_pselx   = 1'b0;
      bus.apb_penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_cmd_valid", {31'd0, bus.o_icb_cmd_valid}, 32'd0);

      // Fresh read after reset release
      xfer(1'b0, 32'h1001_3005, 32'h0, 0, 0, 32'h0000_00C3, 1'b0, 3, 32'h0000_00C3, 1'b0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
